// File: rtl/alu_unit.sv
// alu_unit: registered WIDTH-bit ALU (arith/logic/shift); in clk rst in_valid a b main_sel sub_sel cin, out result cout zero out_valid
module alu_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       main_sel,
  input  logic [1:0]       sub_sel,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             out_valid
);
  logic [WIDTH-1:0] w_opb, w_log, w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_c;
  logic [WIDTH-1:0] r_result;
  logic             r_cout, r_zero, r_valid;
  always_comb begin
    w_opb = sub_sel == 2'b00 ? '0 : sub_sel == 2'b01 ? b : sub_sel == 2'b10 ? ~b : '1;
    w_sum = {1'b0, a} + {1'b0, w_opb} + {{WIDTH{1'b0}}, cin};
    w_log = sub_sel == 2'b00 ? a & b : sub_sel == 2'b01 ? a | b : sub_sel == 2'b10 ? a ^ b : ~a;
    w_res = main_sel == 2'b00 ? w_sum[WIDTH-1:0] :
            main_sel == 2'b01 ? w_log :
            main_sel == 2'b10 ? {1'b0, a[WIDTH-1:1]} : {a[WIDTH-2:0], 1'b0};
    w_c   = main_sel == 2'b00 ? w_sum[WIDTH] :
            main_sel == 2'b01 ? 1'b0 :
            main_sel == 2'b10 ? a[0] : a[WIDTH-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_res;
        r_cout   <= w_c;
        r_zero   <= w_res == '0;
      end
    end
  end
  assign result    = r_result;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign out_valid = r_valid;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: randomized and directed self-checking bench for alu_unit against an integer reference model
module tb_alu_unit;
  localparam int W = 4;
  localparam int M = 1 << W;
  logic clk = 1'b0, rst, in_valid, cin;
  logic [W-1:0] a, b, result;
  logic [1:0] main_sel, sub_sel;
  logic cout, zero, out_valid;
  int n_chk = 0, n_fail = 0;
  int e_res = 0, e_c = 0, e_z = 1, e_v = 0;
  alu_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .main_sel(main_sel), .sub_sel(sub_sel), .cin(cin),
    .result(result), .cout(cout), .zero(zero), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic r, input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [1:0] ms, input logic [1:0] ss, input logic ic);
    int s;
    @(negedge clk);
    rst = r; in_valid = v; a = ia; b = ib; main_sel = ms; sub_sel = ss; cin = ic;
    @(posedge clk);
    #1;
    if (r) begin
      e_res = 0; e_c = 0; e_z = 1; e_v = 0;
    end else begin
      e_v = int'(v);
      if (v) begin
        case (ms)
          2'd0: begin
            case (ss)
              2'd0: s = int'(ia) + int'(ic);
              2'd1: s = int'(ia) + int'(ib) + int'(ic);
              2'd2: s = int'(ia) - int'(ib) - 1 + int'(ic) + M;
              default: s = int'(ia) - 1 + int'(ic) + M;
            endcase
            e_res = s % M; e_c = (s >= M) ? 1 : 0;
          end
          2'd1: begin
            case (ss)
              2'd0: e_res = int'(ia) & int'(ib);
              2'd1: e_res = int'(ia) | int'(ib);
              2'd2: e_res = int'(ia) ^ int'(ib);
              default: e_res = M - 1 - int'(ia);
            endcase
            e_c = 0;
          end
          2'd2: begin e_res = int'(ia) / 2; e_c = int'(ia) % 2; end
          default: begin e_res = (int'(ia) * 2) % M; e_c = int'(ia) / (M / 2); end
        endcase
        e_z = (e_res == 0) ? 1 : 0;
      end
    end
    check("result", 32'(result), 32'(e_res));
    check("cout", 32'(cout), 32'(e_c));
    check("zero", 32'(zero), 32'(e_z));
    check("out_valid", 32'(out_valid), 32'(e_v));
  endtask
  initial begin
    logic [3:0] ar_res [8] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd1, 4'd2, 4'd3};
    logic [3:0] lg_res [4] = '{4'b0000, 4'b0001, 4'b0001, 4'b1110};
    logic [3:0] sh_a [2] = '{4'b0010, 4'b1001};
    logic [3:0] sh_res [4] = '{4'b0001, 4'b0100, 4'b0100, 4'b0010};
    logic sh_c [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    drive(1'b1, 1'b0, '0, '0, 2'd0, 2'd0, 1'b0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 4'b0011, 4'b0010, 2'd0, 2'(i / 2), 1'(i % 2));
      check("arith_tbl", 32'(result), 32'(ar_res[i]));
      check("arith_tbl_c", 32'(cout), (i >= 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 4'b0001, 4'b0000, 2'd1, 2'(i), 1'bx);
      check("logic_tbl", 32'(result), 32'(lg_res[i]));
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, sh_a[i / 2], 4'bxxxx, 2'(2 + i % 2), 2'bxx, 1'bx);
      check("shift_tbl", 32'(result), 32'(sh_res[i]));
      check("shift_tbl_c", 32'(cout), 32'(sh_c[i]));
    end
    drive(1'b0, 1'b1, 4'b1111, 4'b0000, 2'd0, 2'd0, 1'b1);
    check("wrap_result", 32'(result), 32'd0);
    check("wrap_cout", 32'(cout), 32'd1);
    drive(1'b0, 1'b1, 4'b0110, 4'b0011, 2'd0, 2'd1, 1'b0);
    drive(1'b0, 1'b0, 4'b1111, 4'b1111, 2'd1, 2'd1, 1'b0);
    check("hold_result", 32'(result), 32'd9);
    drive(1'b1, 1'b1, 4'b0110, 4'b0011, 2'd0, 2'd1, 1'b0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 1'b0, 4'b0101, 4'b0101, 2'd0, 2'd1, 1'b1);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0, W'($urandom), W'($urandom),
            2'($urandom), 2'($urandom), 1'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
